// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives an R2R ladder as a trial DAC,
// reads the external comparator back and resolves one result bit per trial, MSB first.
module sar_adc_ctrl #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 100,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             comp_in,
    output logic [WIDTH-1:0] dac_out,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WIDTH-1:0] DAC_MSB  = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WIDTH-1:0]       dac_q, dac_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic                   valid_q, valid_d;
    logic                   comp_s;

    // Comparator is asynchronous to clk; the chain free-runs even when disabled.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], comp_in};
    assign comp_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            idx_q    <= IDX_MSB;
            dac_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dac_q    <= dac_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable && start) state_d = S_SETTLE;
            S_SETTLE: if (enable && cnt_q == '0) state_d = S_DECIDE;
            S_DECIDE: if (enable) state_d = (idx_q == '0) ? S_DONE : S_SETTLE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dac_d    = dac_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && start) begin
                    dac_d = DAC_MSB;
                    idx_d = IDX_MSB;
                    cnt_d = CNT_LOAD;
                end
            end
            S_SETTLE: begin
                if (enable && cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
            end
            S_DECIDE: begin
                if (enable) begin
                    // Resolve the current bit and, if more remain, raise the next trial bit in the same update.
                    if (!comp_s) dac_d[idx_q] = 1'b0;
                    if (idx_q == '0) begin
                        result_d = dac_d;
                        valid_d  = 1'b1;
                    end else begin
                        dac_d[idx_q - IDX_ONE] = 1'b1;
                        idx_d = idx_q - IDX_ONE;
                        cnt_d = CNT_LOAD;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        dac_out      = dac_q;
        result       = result_q;
        result_valid = valid_q;
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl with an ideal comparator (comp_in = VIN >= dac_out).
`timescale 1ns/1ps
module tb_sar_adc_ctrl;

    localparam int unsigned W    = 8;
    localparam int unsigned LAT  = 41; // start sample -> result_valid with SETTLE_CYCLES=4

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         start = 1'b0;
    logic         comp_in;
    logic [W-1:0] dac_out;
    logic         busy;
    logic [W-1:0] result;
    logic         result_valid;
    logic [W-1:0] vin = '0;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [W-1:0] code;
        int unsigned  when;
    } exp_t;
    exp_t sb_q[$];

    sar_adc_ctrl #(
        .WIDTH(W),
        .SETTLE_CYCLES(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .start(start),
        .comp_in(comp_in),
        .dac_out(dac_out),
        .busy(busy),
        .result(result),
        .result_valid(result_valid)
    );

    assign comp_in = (vin >= dac_out);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Trial code k of a binary search for v: top k bits already resolved, bit W-1-k under test.
    function automatic logic [W-1:0] trial(input logic [W-1:0] v, input int unsigned k);
        logic [W-1:0] keep;
        logic [W-1:0] top;
        keep = 8'hFF;
        top  = 8'h80;
        keep = keep << (W - k);
        top  = top >> k;
        return (v & keep) | top;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (result_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result 0x%0h at cycle %0d, required no pulse", result, cyc);
            end else begin
                e = sb_q.pop_front();
                check("valid_cycle", cyc, e.when);
                check("result_value", result, e.code);
            end
        end
    end

    task automatic run_conv(input logic [W-1:0] v, input bit chk_trials,
                            input int unsigned gap_off, input int unsigned gap_len, input bit extra);
        int unsigned t0;
        logic [W-1:0] prev;
        bit drained;
        @(negedge clk);
        prev   = result;
        vin    = v;
        enable = 1'b1;
        start  = 1'b1;
        t0     = cyc;
        check("busy_before", busy, 0);
        sb_q.push_back('{v, t0 + LAT + gap_len});
        drained = 1'b0;
        for (int n = 0; n < 300 && !drained; n++) begin
            @(negedge clk);
            start = extra && (cyc == t0 + 5 || cyc == t0 + 20);
            if (gap_len != 0) begin
                if (cyc == t0 + gap_off) enable = 1'b0;
                if (cyc == t0 + gap_off + gap_len) enable = 1'b1;
            end
            if (cyc == t0 + 1) begin
                check("busy_start", busy, 1);
                check("first_trial", dac_out, 8'h80);
            end
            if (chk_trials && cyc >= t0 + 1 && cyc <= t0 + 40)
                check("trial_code", dac_out, trial(v, (cyc - t0 - 1) / 5));
            if (chk_trials && cyc == t0 + LAT)
                check("busy_last", busy, 1);
            if (cyc == t0 + 20) check("result_stable", result, prev);
            if (sb_q.size() == 0) drained = 1'b1;
        end
        if (!drained) begin
            checks++;
            errors++;
            $display("FAIL conv_timeout: got no result_valid for vin 0x%0h, required one", v);
            sb_q.delete();
        end
        enable = 1'b1;
        @(negedge clk);
        check("busy_after", busy, 0);
        check("result_hold", result, v);
        check("dac_hold", dac_out, v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1);
    end

    initial begin
        int unsigned t0;
        bit hit;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_dac", dac_out, 0);
            check("idle_result", result, 0);
            check("idle_busy", busy, 0);
        end

        enable = 1'b0;
        start  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("disabled_start_busy", busy, 0);
        end
        start  = 1'b0;
        enable = 1'b1;

        run_conv(8'hA5, 1'b1, 0, 0, 1'b0);
        run_conv(8'h00, 1'b1, 0, 0, 1'b0);
        run_conv(8'hFF, 1'b1, 0, 0, 1'b0);
        run_conv(8'h3C, 1'b0, 12, 10, 1'b1);

        @(negedge clk);
        vin   = 8'h33;
        start = 1'b1;
        t0    = cyc;
        sb_q.push_back('{8'h33, t0 + LAT});
        hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == t0 + 20) hit = 1'b1;
        end
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("rst_dac", dac_out, 0);
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        run_conv(8'h7E, 1'b1, 0, 0, 1'b0);

        @(negedge clk);
        vin   = 8'h55;
        start = 1'b1;
        t0    = cyc;
        for (int k = 0; k < 3; k++) sb_q.push_back('{8'h55, t0 + LAT + 42 * k});
        hit = 1'b0;
        for (int n = 0; n < 400 && !hit; n++) begin
            @(negedge clk);
            if (cyc == t0 + 125) hit = 1'b1;
        end
        start = 1'b0;
        for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("held_done_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] v;
            int unsigned len;
            int unsigned off;
            v   = W'($urandom_range(0, 255));
            len = $urandom_range(0, 8);
            off = $urandom_range(2, 30);
            run_conv(v, len == 0, off, len, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
